// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return-address stack.
// Holds the action encoding and the depth-counter width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    ACT_CLR  = 3'd0,
    ACT_RET  = 3'd1,
    ACT_CALL = 3'd2,
    ACT_LOAD = 3'd3,
    ACT_INC  = 3'd4,
    ACT_HOLD = 3'd5
  } pc_action_e;

  // Depth counts 0..STACK_DEPTH inclusive, hence the +1.
  function automatic int pc_depth_w(input int stack_depth);
    return $clog2(stack_depth + 1);
  endfunction

  localparam int PC_DEPTH_W_DEFAULT = pc_depth_w(4);

endpackage

// File: rtl/pc_return_stack.sv
// LIFO return-address storage with a depth counter.
// The caller guarantees at most one of push/pop/clear per cycle.
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int DW         = pc_depth_w(STACK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic [DW-1:0]    depth
);

  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (depth == DW'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign do_push = push && !full && !clear && !pop;
  assign do_pop  = pop && !empty && !clear;
  assign top_idx = depth - DW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (clear) begin
      depth <= '0;
    end else if (do_pop) begin
      depth <= depth - DW'(1);
    end else if (do_push) begin
      depth <= depth + DW'(1);
    end
  end

  // Entry contents need no reset; only depth defines what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (do_push && depth == DW'(i)) begin
        mem[i] <= push_data;
      end
    end
  end

  always_comb begin
    top_data = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (top_idx == DW'(i)) begin
        top_data = mem[i];
      end
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Parametrised program counter with CALL/RET return-address stack and
// explicit bus data/enable pair for pad-level output enables.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             lp,
  input  logic             cp,
  input  logic             ep,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic [WIDTH-1:0] pc,
  output logic             wrap,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int DW = pc_depth_w(STACK_DEPTH);

  pc_action_e       act;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top_data;
  logic [DW-1:0]    depth;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             err_set;

  assign pc_inc = pc + WIDTH'(1);

  always_comb begin
    if (!clr_n)    act = ACT_CLR;
    else if (ret)  act = ACT_RET;
    else if (call) act = ACT_CALL;
    else if (lp)   act = ACT_LOAD;
    else if (cp)   act = ACT_INC;
    else           act = ACT_HOLD;
  end

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (act)
      ACT_CLR:  pc_next = RESET_VECTOR;
      ACT_RET: begin
        if (empty) begin
          err_set = 1'b1;
        end else begin
          pop     = 1'b1;
          pc_next = top_data;
        end
      end
      ACT_CALL: begin
        if (full) begin
          err_set = 1'b1;
        end else begin
          push    = 1'b1;
          pc_next = bus_in;
        end
      end
      ACT_LOAD: pc_next = bus_in;
      ACT_INC:  pc_next = pc_inc;
      default:  pc_next = pc;
    endcase
  end

  pc_return_stack #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clear    (act == ACT_CLR),
    .push_data(pc_inc),
    .top_data (top_data),
    .full     (full),
    .empty    (empty),
    .depth    (depth)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_VECTOR;
      wrap      <= 1'b0;
      stack_err <= 1'b0;
      bus_oe    <= 1'b0;
    end else begin
      pc     <= pc_next;
      wrap   <= (act == ACT_INC) && (pc == '1);
      bus_oe <= ep;
      if (act == ACT_CLR) begin
        stack_err <= 1'b0;
      end else if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

  assign bus_out     = bus_oe ? pc : '0;
  assign stack_full  = (depth == DW'(STACK_DEPTH));
  assign stack_empty = (depth == '0);

endmodule
